// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a frame serialiser with CTS gating,
// optional parity, one or two stop bits and break generation, paced by tx_tick.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_tick,
  input  logic [1:0]                  i_num_bit_data,
  input  logic                        i_parity_en,
  input  logic                        i_parity_type,
  input  logic                        i_stop_2,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_wr_ovf,
  input  logic                        i_cts_n,
  input  logic                        i_break,
  output logic                        o_busy,
  output logic                        o_tx_done,
  output logic                        o_tx_serial
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_e;

  // Parity over data bits 0..last_idx; the odd flag seeds the inversion.
  function automatic logic parity_f(input logic [7:0] data, input logic [2:0] last_idx,
                                    input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= last_idx) begin
        p = p ^ data[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  logic [SYNC_STAGES-1:0] cts_sync_q;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          count_q, count_d;
  logic                   full_q, empty_q, ovf_q;

  state_e                 state_q;
  logic [7:0]             data_q;
  logic [2:0]             bit_cnt_q, last_idx_q;
  logic                   par_en_q, par_odd_q, stop2_q;
  logic                   line_q, done_q, busy_q;

  logic                   cts_ok_s, push_s, pop_s, idle_slot_s, eof_slot_s, launch_s;
  logic [7:0]             head_s;

  assign cts_ok_s    = ~cts_sync_q[SYNC_STAGES-1];
  assign push_s      = i_wr_en & ~full_q;
  assign head_s      = mem_q[rd_ptr_q];
  // End-of-frame ticks are treated as IDLE ticks so frames can run back-to-back.
  assign eof_slot_s  = ((state_q == S_STOP1) & ~stop2_q) | (state_q == S_STOP2);
  assign idle_slot_s = (state_q == S_IDLE) | eof_slot_s;
  assign launch_s    = ~i_break & ~empty_q & cts_ok_s;
  assign pop_s       = tx_tick & idle_slot_s & launch_s;

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_level     = count_q;
  assign o_wr_ovf    = ovf_q;
  assign o_busy      = busy_q;
  assign o_tx_done   = done_q;
  assign o_tx_serial = line_q;

  // CTS synchroniser; resets to "not clear to send".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      cts_sync_q <= {cts_sync_q[SYNC_STAGES-2:0], i_cts_n};
    end
  end

  // Next occupancy from the accepted push and pop of this cycle.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_L);
      empty_q <= (count_d == '0);
      ovf_q   <= i_wr_en & full_q;
    end
  end

  // Frame FSM with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= 8'h00;
      bit_cnt_q  <= 3'd0;
      last_idx_q <= 3'd7;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      line_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tx_tick) begin
        if (idle_slot_s) begin
          done_q <= eof_slot_s;
          if (i_break) begin
            state_q <= S_BREAK;
            line_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (launch_s) begin
            state_q    <= S_START;
            line_q     <= 1'b0;
            busy_q     <= 1'b1;
            data_q     <= head_s;
            last_idx_q <= 3'd4 + {1'b0, i_num_bit_data};
            par_en_q   <= i_parity_en;
            par_odd_q  <= i_parity_type;
            stop2_q    <= i_stop_2;
          end else begin
            state_q <= S_IDLE;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end else begin
          case (state_q)
            S_START: begin
              state_q   <= S_DATA;
              line_q    <= data_q[0];
              bit_cnt_q <= 3'd0;
            end
            S_DATA: begin
              if (bit_cnt_q == last_idx_q) begin
                if (par_en_q) begin
                  state_q <= S_PARITY;
                  line_q  <= parity_f(data_q, last_idx_q, par_odd_q);
                end else begin
                  state_q <= S_STOP1;
                  line_q  <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                line_q    <= data_q[bit_cnt_q + 3'd1];
              end
            end
            S_PARITY: begin
              state_q <= S_STOP1;
              line_q  <= 1'b1;
            end
            S_STOP1: begin
              state_q <= S_STOP2;
              line_q  <= 1'b1;
            end
            S_BREAK: begin
              if (!i_break) begin
                state_q <= S_IDLE;
                line_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
            default: begin
              state_q <= S_IDLE;
              line_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// rounds compared against a frame-level bitstream model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_tick = 1'b0;
  logic [1:0] num_bits;
  logic       par_en, par_type, stop_2, wr_en, cts_n, brk;
  logic [7:0] wr_data;
  logic       full, empty, wr_ovf, busy, tx_done, tx_serial;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit cap_q[$];
  bit exp_bits[$];
  int exp_len[$];

  uart_tx_fifo #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_tick(tx_tick),
    .i_num_bit_data(num_bits), .i_parity_en(par_en), .i_parity_type(par_type),
    .i_stop_2(stop_2), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_level(level), .o_wr_ovf(wr_ovf),
    .i_cts_n(cts_n), .i_break(brk), .o_busy(busy), .o_tx_done(tx_done),
    .o_tx_serial(tx_serial)
  );

  initial forever #5 clk = ~clk;

  // Baud tick: one cycle in four.
  initial begin
    int tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      tx_tick = (tcnt % 4 == 0);
    end
  end

  // Line sampled just after every ticked edge; done pulses counted.
  initial begin
    bit t;
    forever begin
      @(posedge clk);
      t = tx_tick;
      #1;
      if (t) cap_q.push_back(tx_serial);
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, N data bits LSB first, optional parity, stop bit(s).
  task automatic add_frame(input logic [7:0] d, input int nb, input bit pen,
                           input bit podd, input bit s2);
    bit p;
    int len;
    p = podd;
    len = 0;
    exp_bits.push_back(1'b0); len++;
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(d[i]); len++;
      p = p ^ d[i];
    end
    if (pen) begin exp_bits.push_back(p); len++; end
    exp_bits.push_back(1'b1); len++;
    if (s2) begin exp_bits.push_back(1'b1); len++; end
    exp_len.push_back(len);
  endtask

  task automatic compare_stream(input string tag, input bit gap);
    int pos = 0;
    int k = 0;
    bit short_s = 0;
    while (pos < cap_q.size() && cap_q[pos] == 1'b1) pos++;
    foreach (exp_len[f]) begin
      if (gap && f > 0) while (pos < cap_q.size() && cap_q[pos] == 1'b1) pos++;
      for (int j = 0; j < exp_len[f]; j++) begin
        if (pos >= cap_q.size()) begin
          if (!short_s) chk({tag, "_short"}, 32'(cap_q.size()), 32'(pos + 1));
          short_s = 1;
        end else begin
          chk($sformatf("%s_f%0d_b%0d", tag, f, j), 32'(cap_q[pos]), 32'(exp_bits[k]));
          pos++;
        end
        k++;
      end
    end
    exp_bits.delete();
    exp_len.delete();
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && empty === 1'b1) ok = 1;
    end
    if (!ok) chk({tag, "_idle_timeout"}, {30'd0, busy, empty}, 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b1) ok = 1;
    end
    if (!ok) chk({tag, "_busy_timeout"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > base) ok = 1;
    end
    if (!ok) chk({tag, "_done_timeout"}, 32'(done_cnt), 32'(base + 1));
  endtask

  task automatic set_cfg(input int nb, input bit pen, input bit podd, input bit s2);
    num_bits = 2'(nb - 5);
    par_en = pen;
    par_type = podd;
    stop_2 = s2;
  endtask

  task automatic run_one(input string tag, input logic [7:0] d, input int nb,
                         input bit pen, input bit podd, input bit s2);
    int base;
    set_cfg(nb, pen, podd, s2);
    cap_q.delete();
    base = done_cnt;
    push(d);
    add_frame(d, nb, pen, podd, s2);
    chk({tag, "_level1"}, 32'(level), 32'd1);
    wait_busy(tag, 100);
    // Config changes mid-frame must not alter the frame in flight.
    num_bits = ~num_bits;
    par_en = ~par_en;
    stop_2 = ~stop_2;
    wait_idle(tag, 400);
    compare_stream(tag, 1'b0);
    chk({tag, "_done"}, 32'(done_cnt - base), 32'd1);
    chk({tag, "_level0"}, 32'(level), 32'd0);
  endtask

  initial begin
    int base, n;
    int nb;
    bit pen, podd, s2;
    logic [7:0] d;

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; cts_n = 1'b1; brk = 1'b0;
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(wr_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_line", 32'(tx_serial), 32'd1);
    rst_n = 1'b1;
    cts_n = 1'b0;
    repeat (6) @(negedge clk);

    run_one("8N1_A5", 8'hA5, 8, 1'b0, 1'b0, 1'b0);
    run_one("7E2_55", 8'h55, 7, 1'b1, 1'b0, 1'b1);
    run_one("8O1_A5", 8'hA5, 8, 1'b1, 1'b1, 1'b0);
    run_one("5E1_FF", 8'hFF, 5, 1'b1, 1'b0, 1'b0);

    // FIFO fill with CTS held off, overflow, then back-to-back drain.
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    repeat (6) @(negedge clk);
    cap_q.delete();
    base = done_cnt;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      push(d);
      add_frame(d, 8, 1'b0, 1'b0, 1'b0);
    end
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    push(8'h3C);
    chk("ovf_pulse", 32'(wr_ovf), 32'd1);
    @(negedge clk);
    chk("ovf_clear", 32'(wr_ovf), 32'd0);
    chk("ovf_level", 32'(level), 32'd16);
    repeat (20) @(negedge clk);
    chk("cts_hold_busy", 32'(busy), 32'd0);
    chk("cts_hold_line", 32'(tx_serial), 32'd1);
    cts_n = 1'b0;
    wait_idle("drain", 5000);
    compare_stream("drain", 1'b0);
    chk("drain_done", 32'(done_cnt - base), 32'd16);

    // CTS deasserted mid-frame: frame completes, next one held.
    cap_q.delete();
    base = done_cnt;
    push(8'h96); add_frame(8'h96, 8, 1'b0, 1'b0, 1'b0);
    push(8'h0F); add_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0);
    wait_busy("ctsmid", 100);
    repeat (16) @(negedge clk);
    cts_n = 1'b1;
    wait_done("ctsmid", base, 200);
    repeat (40) @(negedge clk);
    chk("ctsmid_busy", 32'(busy), 32'd0);
    chk("ctsmid_level", 32'(level), 32'd1);
    chk("ctsmid_line", 32'(tx_serial), 32'd1);
    cts_n = 1'b0;
    wait_idle("ctsmid", 400);
    compare_stream("ctsmid", 1'b1);
    chk("ctsmid_done", 32'(done_cnt - base), 32'd2);

    // Break requested mid-frame.
    cap_q.delete();
    base = done_cnt;
    push(8'hC3); add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0);
    wait_busy("brk", 100);
    repeat (12) @(negedge clk);
    brk = 1'b1;
    wait_done("brk", base, 200);
    chk("brk_line0", 32'(tx_serial), 32'd0);
    chk("brk_busy", 32'(busy), 32'd1);
    compare_stream("brk_frame", 1'b0);
    push(8'h5A);
    repeat (20) @(negedge clk);
    chk("brk_hold_line", 32'(tx_serial), 32'd0);
    chk("brk_hold_level", 32'(level), 32'd1);
    chk("brk_no_done", 32'(done_cnt - base), 32'd1);
    brk = 1'b0;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (tx_serial === 1'b1) ok = 1;
      end
      chk("brk_release_line", 32'(tx_serial), 32'd1);
    end
    chk("brk_release_busy", 32'(busy), 32'd0);
    cap_q.delete();
    add_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    wait_idle("brk_next", 400);
    compare_stream("brk_next", 1'b0);
    chk("brk_next_done", 32'(done_cnt - base), 32'd2);

    // Reset while in DATA, line low from a zero byte.
    push(8'h00);
    push(8'h00);
    wait_busy("rstmid", 100);
    repeat (12) @(negedge clk);
    chk("rstmid_pre_line", 32'(tx_serial), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_line", 32'(tx_serial), 32'd1);
    chk("rstmid_level", 32'(level), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Randomized rounds: random config and burst, must drain back-to-back.
    for (int r = 0; r < 6; r++) begin
      nb = int'($urandom_range(8, 5));
      pen = 1'($urandom);
      podd = 1'($urandom);
      s2 = 1'($urandom);
      set_cfg(nb, pen, podd, s2);
      n = int'($urandom_range(6, 2));
      cap_q.delete();
      base = done_cnt;
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        push(d);
        add_frame(d, nb, pen, podd, s2);
      end
      wait_idle($sformatf("rnd%0d", r), 3000);
      compare_stream($sformatf("rnd%0d", r), 1'b0);
      chk($sformatf("rnd%0d_done", r), 32'(done_cnt - base), 32'(n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
